// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer, status and FWFT prefetch control for a 1R/1W
// synchronous FIFO RAM with a one-cycle registered read.
// The RAM holds up to DEPTH entries and a 2-entry head/skid buffer plus
// one in-flight fetch sit in front of it, so the consumer sees
// first-word-fall-through data with no read latency.
// Optional build macro FIFO_CTRL_LEVEL_EN adds a registered 'level'
// output giving the total number of stored entries.
module fifo_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_BITS  = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic                  full,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  pop_valid,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  ram_wr_en,
    output logic [ADDR_BITS-1:0]  ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic [ADDR_BITS-1:0]  ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data
`ifdef FIFO_CTRL_LEVEL_EN
    ,
    output logic [ADDR_BITS+1:0]  level
`endif
);

    localparam int PTR_W = ADDR_BITS + 1;
    localparam logic [PTR_W-1:0] DEPTH_PTR = {1'b1, {ADDR_BITS{1'b0}}};

    // Registered state
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic                  fetch_pending_r;
    logic [1:0]            buf_cnt_r;
    logic [DATA_WIDTH-1:0] head_r;
    logic [DATA_WIDTH-1:0] skid_r;
    logic                  full_r;
    logic                  pop_valid_r;
    logic                  overflow_r;
    logic                  underflow_r;

    // Combinational next-state terms
    logic [PTR_W-1:0]      ram_count_s;
    logic                  push_ok_s;
    logic                  pop_ok_s;
    logic [2:0]            demand_s;
    logic                  fetch_s;
    logic [PTR_W-1:0]      wr_ptr_nxt_s;
    logic [PTR_W-1:0]      rd_ptr_nxt_s;
    logic [PTR_W-1:0]      ram_count_nxt_s;
    logic [1:0]            cnt_nxt_s;
    logic [DATA_WIDTH-1:0] head_nxt_s;
    logic [DATA_WIDTH-1:0] skid_nxt_s;

    // Pointer arithmetic and fetch decision. The fetch only reads entries
    // already counted in ram_count, so it never hits the address being
    // written this cycle. demand_s is the buffer occupancy once the
    // pending capture and this cycle's pop have settled.
    always_comb begin
        ram_count_s     = wr_ptr_r - rd_ptr_r;
        push_ok_s       = push & ~full_r;
        pop_ok_s        = pop & pop_valid_r;
        demand_s        = {1'b0, buf_cnt_r} + {2'b00, fetch_pending_r} - {2'b00, pop_ok_s};
        fetch_s         = (ram_count_s != {PTR_W{1'b0}}) && (demand_s < 3'd2);
        wr_ptr_nxt_s    = wr_ptr_r + {{ADDR_BITS{1'b0}}, push_ok_s};
        rd_ptr_nxt_s    = rd_ptr_r + {{ADDR_BITS{1'b0}}, fetch_s};
        ram_count_nxt_s = wr_ptr_nxt_s - rd_ptr_nxt_s;
    end

    // Head/skid buffer update: captures fill the first free slot, pops
    // shift the skid forward, and a simultaneous pop+capture keeps order.
    always_comb begin
        head_nxt_s = head_r;
        skid_nxt_s = skid_r;
        cnt_nxt_s  = buf_cnt_r;
        case ({fetch_pending_r, pop_ok_s})
            2'b10: begin
                cnt_nxt_s = buf_cnt_r + 2'd1;
                if (buf_cnt_r == 2'd0) begin
                    head_nxt_s = ram_rd_data;
                end else begin
                    skid_nxt_s = ram_rd_data;
                end
            end
            2'b01: begin
                cnt_nxt_s = buf_cnt_r - 2'd1;
                if (buf_cnt_r == 2'd2) begin
                    head_nxt_s = skid_r;
                end else begin
                    head_nxt_s = head_r;
                end
            end
            2'b11: begin
                cnt_nxt_s = buf_cnt_r;
                if (buf_cnt_r == 2'd2) begin
                    head_nxt_s = skid_r;
                    skid_nxt_s = ram_rd_data;
                end else begin
                    head_nxt_s = ram_rd_data;
                end
            end
            default: begin
                cnt_nxt_s = buf_cnt_r;
            end
        endcase
    end

    // State register; reset drops all contents including an in-flight fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r        <= {PTR_W{1'b0}};
            rd_ptr_r        <= {PTR_W{1'b0}};
            fetch_pending_r <= 1'b0;
            buf_cnt_r       <= 2'd0;
            head_r          <= {DATA_WIDTH{1'b0}};
            skid_r          <= {DATA_WIDTH{1'b0}};
            full_r          <= 1'b0;
            pop_valid_r     <= 1'b0;
            overflow_r      <= 1'b0;
            underflow_r     <= 1'b0;
        end else begin
            wr_ptr_r        <= wr_ptr_nxt_s;
            rd_ptr_r        <= rd_ptr_nxt_s;
            fetch_pending_r <= fetch_s;
            buf_cnt_r       <= cnt_nxt_s;
            head_r          <= head_nxt_s;
            skid_r          <= skid_nxt_s;
            full_r          <= (ram_count_nxt_s == DEPTH_PTR);
            pop_valid_r     <= (cnt_nxt_s != 2'd0);
            overflow_r      <= overflow_r | (push & full_r);
            underflow_r     <= underflow_r | (pop & ~pop_valid_r);
        end
    end

`ifdef FIFO_CTRL_LEVEL_EN
    logic [ADDR_BITS+1:0] level_r;

    // Total stored entries (RAM + buffer + in-flight) tracking current state.
    always_ff @(posedge clk) begin
        if (reset) begin
            level_r <= {(ADDR_BITS+2){1'b0}};
        end else begin
            level_r <= {1'b0, ram_count_nxt_s}
                     + {{ADDR_BITS{1'b0}}, cnt_nxt_s}
                     + {{(ADDR_BITS+1){1'b0}}, fetch_s};
        end
    end

    assign level = level_r;
`endif

    assign full        = full_r;
    assign pop_data    = head_r;
    assign pop_valid   = pop_valid_r;
    assign overflow    = overflow_r;
    assign underflow   = underflow_r;
    assign ram_wr_en   = push_ok_s;
    assign ram_wr_addr = wr_ptr_r[ADDR_BITS-1:0];
    assign ram_wr_data = push_data;
    assign ram_rd_addr = rd_ptr_r[ADDR_BITS-1:0];

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl (DATA_WIDTH=16, ADDR_BITS=2).
// A behavioural RAM model is attached; expectations come from a queue of
// accepted data plus occupancy counts for RAM, in-flight and visible entries.
module tb_fifo_ctrl;

    localparam int DW    = 16;
    localparam int AB    = 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          push;
    logic [DW-1:0] push_data;
    logic          full;
    logic          pop;
    logic [DW-1:0] pop_data;
    logic          pop_valid;
    logic          overflow;
    logic          underflow;
    logic          ram_wr_en;
    logic [AB-1:0] ram_wr_addr;
    logic [DW-1:0] ram_wr_data;
    logic [AB-1:0] ram_rd_addr;
    logic [DW-1:0] ram_rd_data;
`ifdef FIFO_CTRL_LEVEL_EN
    logic [AB+1:0] level;
`endif

    fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_BITS(AB)) dut (
        .clk(clk), .reset(reset),
        .push(push), .push_data(push_data), .full(full),
        .pop(pop), .pop_data(pop_data), .pop_valid(pop_valid),
        .overflow(overflow), .underflow(underflow),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
        .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data)
`ifdef FIFO_CTRL_LEVEL_EN
        , .level(level)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous RAM with registered read
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
        ram_rd_data <= mem[ram_rd_addr];
    end

    // Reference model state
    logic [DW-1:0] q[$];
    int ram_n, fly_n, vis_n, wr_tot, rd_tot;
    bit m_ovf, m_unf;
    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        ram_n = 0; fly_n = 0; vis_n = 0; wr_tot = 0; rd_tot = 0;
        m_ovf = 1'b0; m_unf = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; push = 1'b0; pop = 1'b0; push_data = '0;
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        #1;
        chk("rst_pop_data", 32'(pop_data), 32'h0);
        chk("rst_pop_valid", 32'(pop_valid), 32'h0);
        chk("rst_full", 32'(full), 32'h0);
        chk("rst_overflow", 32'(overflow), 32'h0);
        chk("rst_underflow", 32'(underflow), 32'h0);
`ifdef FIFO_CTRL_LEVEL_EN
        chk("rst_level", 32'(level), 32'h0);
`endif
    endtask

    // One clock cycle: drive inputs, check outputs against model, advance model.
    task automatic step(input bit p, input logic [DW-1:0] d, input bit o);
        bit full_e, valid_e, push_ok, pop_ok, fetch;
        @(negedge clk);
        push = p; push_data = d; pop = o;
        #1;
        full_e  = (ram_n == DEPTH);
        valid_e = (vis_n > 0);
        chk("pop_valid", 32'(pop_valid), 32'(valid_e));
        chk("full", 32'(full), 32'(full_e));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_unf));
        chk("ram_wr_en", 32'(ram_wr_en), 32'(p && !full_e));
        chk("ram_wr_data", 32'(ram_wr_data), 32'(d));
        chk("ram_wr_addr", 32'(ram_wr_addr), 32'(wr_tot % DEPTH));
        chk("ram_rd_addr", 32'(ram_rd_addr), 32'(rd_tot % DEPTH));
        if (valid_e) chk("pop_data", 32'(pop_data), 32'(q[0]));
`ifdef FIFO_CTRL_LEVEL_EN
        chk("level", 32'(level), 32'(q.size()));
`endif
        push_ok = p && !full_e;
        pop_ok  = o && valid_e;
        fetch   = (ram_n > 0) && ((vis_n + fly_n - int'(pop_ok)) < 2);
        if (p && full_e) m_ovf = 1'b1;
        if (o && !valid_e) m_unf = 1'b1;
        if (push_ok) begin q.push_back(d); wr_tot++; end
        if (pop_ok) void'(q.pop_front());
        if (fetch) rd_tot++;
        ram_n = ram_n + int'(push_ok) - int'(fetch);
        vis_n = vis_n + fly_n - int'(pop_ok);
        fly_n = int'(fetch);
    endtask

    initial begin
        reset = 1'b1; push = 1'b0; pop = 1'b0; push_data = '0;
        model_clear();
        repeat (2) @(negedge clk);
        do_reset();

        // Single push: visible in cycle 3, gone after the pop
        step(1'b1, 16'hA5A5, 1'b0);
        step(1'b0, 16'h0000, 1'b0);
        step(1'b0, 16'h0000, 1'b0);
        step(1'b0, 16'h0000, 1'b1);
        chk("first_latency_valid", 32'(pop_valid), 32'h1);
        chk("first_latency_data", 32'(pop_data), 32'hA5A5);
        step(1'b0, 16'h0000, 1'b0);
        chk("after_pop_valid", 32'(pop_valid), 32'h0);
        chk("after_pop_underflow", 32'(underflow), 32'h0);

        // Fill past capacity, then drain
        for (int i = 1; i <= 8; i++) step(1'b1, 16'(i), 1'b0);
        chk("fill_overflow", 32'(overflow), 32'h1);
        chk("fill_full", 32'(full), 32'h1);
        for (int i = 1; i <= 6; i++) begin
            step(1'b0, 16'h0000, 1'b1);
            chk("drain_order", 32'(pop_data), 32'(i));
        end
        step(1'b0, 16'h0000, 1'b0);
        chk("drained_valid", 32'(pop_valid), 32'h0);

        // Pop while empty: sticky underflow, pointers unchanged
        step(1'b0, 16'h0000, 1'b1);
        step(1'b0, 16'h0000, 1'b0);
        step(1'b0, 16'h0000, 1'b0);
        chk("underflow_sticky", 32'(underflow), 32'h1);
        do_reset();

        // Continuous push/pop after prefetch fills; pointers wrap
        for (int i = 0; i < 4; i++) step(1'b1, 16'($urandom), 1'b0);
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 16'($urandom), 1'b1);
            chk("no_bubble", 32'(pop_valid), 32'h1);
        end
        for (int i = 0; i < 8; i++) step(1'b0, 16'h0000, 1'b1);
        do_reset();

        // Reset during an in-flight fetch, then a fresh entry
        for (int i = 0; i < 3; i++) step(1'b1, 16'(16'hBEE0 + i), 1'b0);
        do_reset();
        step(1'b1, 16'h1234, 1'b0);
        step(1'b0, 16'h0000, 1'b0);
        step(1'b0, 16'h0000, 1'b0);
        step(1'b0, 16'h0000, 1'b1);
        chk("fresh_head", 32'(pop_data), 32'h1234);
        step(1'b0, 16'h0000, 1'b0);

        // Push 5, pop 1 (level 5 then 4 when enabled)
        for (int i = 0; i < 5; i++) step(1'b1, 16'($urandom), 1'b0);
        step(1'b0, 16'h0000, 1'b0);
        step(1'b0, 16'h0000, 1'b1);
        step(1'b0, 16'h0000, 1'b0);
        do_reset();

        // Randomized traffic with varying push/pop mix and occasional resets
        for (int ph = 0; ph < 3; ph++) begin
            int pp, op;
            pp = (ph == 0) ? 70 : (ph == 1) ? 30 : 50;
            op = (ph == 0) ? 30 : (ph == 1) ? 70 : 50;
            for (int i = 0; i < 250; i++) begin
                if ($urandom_range(0, 149) == 0) do_reset();
                step($urandom_range(0, 99) < pp, 16'($urandom), $urandom_range(0, 99) < op);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Synchronous FIFO controller that drives a 1-read/1-write synchronous FIFO RAM (registered read, one-cycle read latency).
- Owns the write/read pointers, full/empty status and a 2-entry first-word-fall-through (FWFT) prefetch buffer. The RAM's read latency is hidden from the consumer, and pop_data is valid whenever pop_valid is high.
- Sits between producer logic and the FIFO RAM instance; pop_data feeds downstream consumers (UART/VGA/audio paths).

Parameters:
DATA_WIDTH, 16, width of each entry; must match the RAM.
ADDR_BITS, 5, RAM address width; RAM depth DEPTH = 2**ADDR_BITS.

Ports:
clk  input  1  system clock; all logic on the rising edge.
reset  input  1  synchronous, active-high reset.
push  input  1  write request; accepted when !full.
push_data  input  DATA_WIDTH  data written on an accepted push.
full  output  1  RAM holds DEPTH entries; pushes are ignored.
pop  input  1  consume the current pop_data; accepted when pop_valid.
pop_data  output  DATA_WIDTH  head-of-FIFO data, valid when pop_valid.
pop_valid  output  1  head entry present (not empty).
overflow  output  1  sticky: a push was attempted while full.
underflow  output  1  sticky: a pop was attempted while !pop_valid.
ram_wr_en  output  1  RAM write enable (= push && !full).
ram_wr_addr  output  ADDR_BITS  RAM write address (wr_ptr low bits).
ram_wr_data  output  DATA_WIDTH  = push_data (combinational).
ram_rd_addr  output  ADDR_BITS  RAM read address (rd_ptr low bits).
ram_rd_data  input  DATA_WIDTH  RAM read data, valid the cycle after ram_rd_addr is presented.

Behaviour:
- Pointers: wr_ptr and rd_ptr are ADDR_BITS+1 bits wide and wrap naturally modulo 2*DEPTH. ram_count = wr_ptr - rd_ptr, computed from registered values only.
- full = (ram_count == DEPTH).
- Reset: wr_ptr=0, rd_ptr=0, fetch_pending=0, buffer count=0, pop_valid=0, pop_data=0, overflow=0, underflow=0, full=0. Reset mid-operation discards all contents, including any in-flight fetch. RAM contents are not cleared.
- Push: when push && !full, ram_wr_en=1 and wr_ptr increments at the edge. A push when full has no effect on pointers or RAM, and sets overflow.
- Read-during-write safety: an entry written at edge N is counted in ram_count from cycle N+1. A fetch never targets the address being written in the same cycle.
- Fetch: ram_rd_addr = rd_ptr[ADDR_BITS-1:0] every cycle. A fetch is issued when ram_count != 0 and (buf_cnt + fetch_pending - pop_accepted) < 2. On a fetch, rd_ptr increments and fetch_pending is set for the next cycle.
- Capture: in a cycle with fetch_pending=1, ram_rd_data is written into the buffer at the edge.
- Buffer: 2 entries, head and skid, tracked by buf_cnt 0..2.
  - pop_data is the head entry; pop_valid = (buf_cnt != 0).
  - Pop and capture in the same cycle: the skid moves to the head and the new entry fills the vacated slot, preserving order.
  - Pop and capture with buf_cnt=1: the captured entry goes directly to the head.
- Pop when !pop_valid has no effect and sets underflow.
- Simultaneous push and pop are fully independent; steady-state throughput is 1 push and 1 pop per cycle.
- Latency: push accepted in cycle 0 into an empty FIFO gives pop_valid=1 in cycle 3 (fetch issued cycle 1, captured cycle 2).
- Total capacity is DEPTH + 2 entries (RAM plus buffer/in-flight); full reflects RAM occupancy only.
- overflow and underflow stay set until reset.

Optional Feature:
- Macro FIFO_CTRL_LEVEL_EN.
- Defined: adds output port level (ADDR_BITS+2 bits) = ram_count + buf_cnt + fetch_pending, registered, 0 after reset, updated every cycle.
- Undefined: the level port and its logic are absent; all other behaviour is identical.

Test Plan:
All tests use DATA_WIDTH=16, ADDR_BITS=2 (DEPTH=4).
- Reset, then one push of 0xA5A5 in cycle 0 -> pop_valid=0 in cycles 1-2, pop_valid=1 with pop_data=0xA5A5 in cycle 3; pop -> pop_valid=0 next cycle, underflow=0.
- Push 0x0001..0x0008 back-to-back with no pops -> 6 accepted; full asserts once the RAM holds 4; pushes 7-8 ignored and overflow=1. Then pop continuously -> 0x0001..0x0006 in order, then pop_valid=0.
- Continuous push and pop every cycle for 40 cycles after prefetch fills -> no bubbles, data order exact, pointers wrap past 7->0 with no corruption.
- Pop with pop_valid=0 -> underflow=1 and sticky; pointers unchanged. Reset -> underflow=0, overflow=0, full=0.
- Fill 3 entries, assert reset during an in-flight fetch -> next cycle pop_valid=0, full=0. A fresh push of 0x1234 emerges as the first popped data.
- With FIFO_CTRL_LEVEL_EN defined: push 5 and pop 1 -> level reaches 5, then 4; after reset level=0.
